// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: address width, canonical NOP and the icache FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ICACHE_IDLE,
        ICACHE_REFILL,
        ICACHE_UPDATE
    } icache_state_t;

endpackage

// File: rtl/icache_refill.sv
// Refill engine for the direct-mapped icache: sequences one line of word requests on the
// valid/ack memory bus, tracks the fill word, and decides whether the finished line may be marked valid.
module icache_refill
    import riscv_pkg::*;
#(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned LINE_WORDS = 4,
    localparam int unsigned WBITS      = $clog2(LINE_WORDS),
    localparam int unsigned OFFS       = 2 + WBITS,
    localparam int unsigned LBITS      = XLEN - OFFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_i,
    input  logic [LBITS-1:0]  miss_line_i,
    input  logic              flush_i,
    output icache_state_t     state_o,
    output logic [LBITS-1:0]  line_o,
    output logic              wr_en_o,
    output logic [WBITS-1:0]  wr_word_o,
    output logic              line_done_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    input  logic              mem_ack_i
);

    icache_state_t     state_q, state_d;
    logic [WBITS-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic [LBITS-1:0]  line_q, line_d;
    logic              drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        adr_d   = adr_q;
        line_d  = line_q;
        drop_d  = drop_q;
        case (state_q)
            ICACHE_IDLE: begin
                if (miss_i) begin
                    state_d = ICACHE_REFILL;
                    line_d  = miss_line_i;
                    req_d   = 1'b1;
                    adr_d   = {miss_line_i, {OFFS{1'b0}}};
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                end
            end
            ICACHE_REFILL: begin
                // A flush during the fill must not let this (possibly stale) line become valid.
                if (flush_i) drop_d = 1'b1;
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    adr_d = adr_q + XLEN'(4);
                    if (cnt_q == WBITS'(LINE_WORDS - 1)) begin
                        req_d   = 1'b0;
                        state_d = ICACHE_UPDATE;
                    end
                end
            end
            ICACHE_UPDATE: begin
                state_d = ICACHE_IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ICACHE_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            adr_q   <= '0;
            line_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            line_q  <= line_d;
            drop_q  <= drop_d;
        end
    end

    assign state_o     = state_q;
    assign line_o      = line_q;
    assign wr_en_o     = (state_q == ICACHE_REFILL) && mem_ack_i && !reset;
    assign wr_word_o   = cnt_q;
    assign line_done_o = (state_q == ICACHE_UPDATE) && !drop_q && !flush_i && !reset;
    assign mem_req_o   = req_q;
    assign mem_adr_o   = adr_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: valid/tag/data arrays with asynchronous read, zero-latency hit path,
// and a refill engine that fills whole lines from a word-wide valid/ack memory bus.
module icache
    import riscv_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NB_LINES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  icache_adr_i,
    input  logic             icache_flush_i,
    output logic [31:0]      icache_instr_o,
    output logic             icache_stall_o,
    output logic             mem_req_o,
    output logic [XLEN-1:0]  mem_adr_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i
);

    localparam int unsigned WBITS = $clog2(LINE_WORDS);
    localparam int unsigned IBITS = $clog2(NB_LINES);
    localparam int unsigned OFFS  = 2 + WBITS;
    localparam int unsigned LBITS = XLEN - OFFS;
    localparam int unsigned TBITS = LBITS - IBITS;

    logic [31:0]       data_q [NB_LINES][LINE_WORDS];
    logic [TBITS-1:0]  tag_q  [NB_LINES];
    logic [NB_LINES-1:0] valid_q;

    logic [WBITS-1:0]  word;
    logic [IBITS-1:0]  idx;
    logic [TBITS-1:0]  tag;
    logic              hit;
    logic              unused_adr_bits;

    icache_state_t     state;
    logic [LBITS-1:0]  fill_line;
    logic [IBITS-1:0]  fill_idx;
    logic              wr_en;
    logic [WBITS-1:0]  wr_word;
    logic              line_done;

    assign word            = icache_adr_i[2 +: WBITS];
    assign idx             = icache_adr_i[OFFS +: IBITS];
    assign tag             = icache_adr_i[XLEN-1 -: TBITS];
    assign unused_adr_bits = ^icache_adr_i[1:0];
    assign fill_idx        = fill_line[IBITS-1:0];

    assign hit            = (state == ICACHE_IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign icache_instr_o = (hit && !reset) ? data_q[idx][word] : NOP_INSTR;
    assign icache_stall_o = !reset && ((state != ICACHE_IDLE) || !hit);

    icache_refill #(
        .XLEN       (XLEN),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk         (clk),
        .reset       (reset),
        .miss_i      ((state == ICACHE_IDLE) && !hit),
        .miss_line_i (icache_adr_i[XLEN-1:OFFS]),
        .flush_i     (icache_flush_i),
        .state_o     (state),
        .line_o      (fill_line),
        .wr_en_o     (wr_en),
        .wr_word_o   (wr_word),
        .line_done_o (line_done),
        .mem_req_o   (mem_req_o),
        .mem_adr_o   (mem_adr_o),
        .mem_ack_i   (mem_ack_i)
    );

    // Flush takes priority over a same-cycle valid-set from the refill engine.
    always_ff @(posedge clk) begin
        if (reset || icache_flush_i) begin
            valid_q <= '0;
        end else if (line_done) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[fill_idx][wr_word] <= mem_rdata_i;
        end
        if (line_done) begin
            tag_q[fill_idx] <= fill_line[LBITS-1:IBITS];
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: fetch stimulus queues expected instruction/stall counts and refill
// addresses; a fetch monitor and a memory model pop and compare as the DUT responds.
module tb_icache;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0]  instr;
        int unsigned  stalls;
    } fetch_exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr   = 32'h0000_0100;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = '0;

    fetch_exp_t  fetch_q[$];
    logic [31:0] adr_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          fetch_active = 1'b0;
    bit          fetch_done   = 1'b0;
    int unsigned stall_cnt    = 0;
    int unsigned wait_states  = 0;
    int unsigned acks_given   = 0;

    icache #(
        .LINE_WORDS (4),
        .NB_LINES   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_adr_i   (adr),
        .icache_flush_i (flush),
        .icache_instr_o (instr),
        .icache_stall_o (stall),
        .mem_req_o      (mem_req),
        .mem_adr_o      (mem_adr),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Memory model: answers requests after wait_states idle cycles, verifying the address each cycle.
    initial begin
        int unsigned waitc;
        waitc = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                if (adr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: request at %08h, expected no request", mem_adr);
                    mem_ack = 1'b0;
                end else begin
                    check32("mem_adr", mem_adr, adr_q[0]);
                    if (waitc == wait_states) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_word(mem_adr);
                        waitc     = 0;
                        acks_given++;
                        void'(adr_q.pop_front());
                    end else begin
                        mem_ack = 1'b0;
                        waitc++;
                    end
                end
            end else begin
                mem_ack = 1'b0;
                waitc   = 0;
            end
        end
    end

    // Fetch monitor: counts stall cycles, compares when the cache presents a hit.
    initial begin
        fetch_exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_active) begin
                if (stall) begin
                    stall_cnt++;
                end else if (fetch_q.size() != 0) begin
                    e = fetch_q.pop_front();
                    check32("instr", instr, e.instr);
                    checks++;
                    if (stall_cnt != e.stalls) begin
                        errors++;
                        $display("FAIL stall_cycles: got %0d expected %0d (adr %08h)", stall_cnt, e.stalls, adr);
                    end
                    fetch_active = 1'b0;
                    fetch_done   = 1'b1;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                         input int unsigned exp_stalls, input int unsigned nfills);
        fetch_exp_t e;
        bit ok;
        @(posedge clk);
        #1;
        reset = 1'b0;
        adr   = a;
        for (int unsigned f = 0; f < nfills; f++)
            for (int unsigned w = 0; w < 4; w++)
                adr_q.push_back({a[31:4], 4'h0} + 32'(4 * w));
        e.instr  = exp_instr;
        e.stalls = exp_stalls;
        fetch_q.push_back(e);
        stall_cnt    = 0;
        fetch_done   = 1'b0;
        fetch_active = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (fetch_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: adr %08h no hit within 200 cycles", a);
            fetch_active = 1'b0;
            fetch_q.delete();
            adr_q.delete();
        end
        fetch_done = 1'b0;
    endtask

    task automatic flush_after(input int unsigned n);
        repeat (n) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        bit          seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_stall", {31'b0, stall}, 32'h0);
        check32("reset_instr", instr, NOP_INSTR);
        check32("reset_req", {31'b0, mem_req}, 32'h0);
        check32("reset_adr", mem_adr, 32'h0);

        fetch(32'h0000_0100, 32'h0000_00A0, 6, 1);
        fetch(32'h0000_010C, 32'h0000_00A3, 0, 0);
        fetch(32'h0000_0104, 32'h0000_00A1, 0, 0);
        fetch(32'h0000_0200, 32'h0000_00E0, 6, 1);
        fetch(32'h0000_0100, 32'h0000_00A0, 6, 1);

        wait_states = 3;
        fetch(32'h0000_05A0, 32'h0000_01C8, 18, 1);
        wait_states = 0;
        fetch(32'h0000_05A8, 32'h0000_01CA, 0, 0);

        // Flush mid-refill: line dropped, same address refills again at once.
        fork
            fetch(32'h0000_0300, 32'h0000_0120, 12, 2);
            flush_after(3);
        join
        fetch(32'h0000_05A8, 32'h0000_01CA, 6, 1);
        fetch(32'h0000_0100, 32'h0000_00A0, 6, 1);

        // Flush in the UPDATE cycle beats the valid-set.
        fork
            fetch(32'h0000_0600, 32'h0000_01E0, 12, 2);
            flush_after(6);
        join

        // Reset coinciding with the second refill ack.
        @(posedge clk);
        #1;
        adr = 32'h0000_0440;
        adr_q.push_back(32'h0000_0440);
        adr_q.push_back(32'h0000_0444);
        base = acks_given;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (acks_given == base + 2) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL second_ack_timeout: got %0d acks expected 2", acks_given - base);
        end
        reset = 1'b1;
        @(negedge clk);
        check32("midreset_req", {31'b0, mem_req}, 32'h0);
        check32("midreset_adr", mem_adr, 32'h0);
        check32("midreset_stall", {31'b0, stall}, 32'h0);
        check32("midreset_instr", instr, NOP_INSTR);
        fetch(32'h0000_0440, 32'h0000_0170, 6, 1);
        fetch(32'h0000_044C, 32'h0000_0173, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("adr_queue_left", 32'(adr_q.size()), 32'h0);
        check32("fetch_queue_left", 32'(fetch_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
